// File: rtl/trace_issue_buffer.sv
// Timed trace front end: buffers timestamped entries and releases each in order
// once the simulated CPU clock reaches its timestamp, with optional idle time-skip.
module trace_issue_buffer #(
    parameter int ADDRESS_WIDTH = 33,
    parameter int TIME_WIDTH    = 32,
    parameter int OP_WIDTH      = 2,
    parameter int DEPTH         = 4,
    parameter int CLK_DIV       = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [TIME_WIDTH-1:0]        in_time,
    input  logic [OP_WIDTH-1:0]          in_op,
    input  logic [ADDRESS_WIDTH-1:0]     in_addr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [TIME_WIDTH-1:0]        out_time,
    output logic [OP_WIDTH-1:0]          out_op,
    output logic [ADDRESS_WIDTH-1:0]     out_addr,
    input  logic                         queue_empty,
    input  logic                         skip_en,
    output logic [TIME_WIDTH-1:0]        cpu_time,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         drop_err,
    output logic                         order_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [DW-1:0] PMAX = DW'(CLK_DIV - 1);

    logic [TIME_WIDTH-1:0]    mem_time [DEPTH];
    logic [OP_WIDTH-1:0]      mem_op   [DEPTH];
    logic [ADDRESS_WIDTH-1:0] mem_addr [DEPTH];

    logic [PW-1:0]         rd_ptr, wr_ptr;
    logic [DW-1:0]         presc;
    logic [TIME_WIDTH-1:0] last_time;
    logic [TIME_WIDTH-1:0] head_time;
    logic                  push, pop, skip, tick, held;

    assign head_time = mem_time[rd_ptr];
    assign held      = (count != '0);
    assign in_ready  = (count != FULL);
    assign out_valid = held && (head_time <= cpu_time);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign skip      = skip_en && queue_empty && held && (head_time > cpu_time);
    assign tick      = (presc == PMAX);

    // Outputs are forced to zero while nothing is due so idle bus values are clean.
    assign out_time = out_valid ? head_time        : '0;
    assign out_op   = out_valid ? mem_op[rd_ptr]   : '0;
    assign out_addr = out_valid ? mem_addr[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_time[wr_ptr] <= in_time;
            mem_op[wr_ptr]   <= in_op;
            mem_addr[wr_ptr] <= in_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Skip jumps straight to the head timestamp and restarts the tick phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc    <= '0;
            cpu_time <= '0;
        end else if (skip) begin
            presc    <= '0;
            cpu_time <= head_time;
        end else begin
            presc <= tick ? '0 : presc + DW'(1);
            if (tick && (cpu_time != '1))
                cpu_time <= cpu_time + TIME_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_time <= '0;
            drop_err  <= 1'b0;
            order_err <= 1'b0;
        end else begin
            if (in_valid && !in_ready) drop_err <= 1'b1;
            if (push) begin
                last_time <= in_time;
                if (in_time < last_time) order_err <= 1'b1;
            end
        end
    end
endmodule
